// File: rtl/org_write.sv
// Fill stage for ram_llr: saturates a stream of signed LLR samples, packs PACK of
// them per word and writes WORD_NUM words, then pulses flag_org_write_end.
module org_write #(
    parameter int LLR_IN_W = 8,
    parameter int LLR_W    = 6,
    parameter int PACK     = 8,
    parameter int WORD_NUM = 64,
    parameter int ADDR_W   = 7
) (
    input  logic                    sys_clk,
    input  logic                    sys_rst_n,
    input  logic                    flag_org_write_start,
    input  logic [LLR_IN_W-1:0]     llr_in,
    input  logic                    llr_valid,
    output logic                    llr_ready,
    output logic [ADDR_W-1:0]       org_wr_addr,
    output logic [LLR_W*PACK-1:0]   org_wr_data,
    output logic                    org_wr_en,
    output logic                    flag_org_write_end,
    output logic [9:0]              sat_cnt
);

    localparam int LANE_W = (PACK > 1) ? $clog2(PACK) : 1;
    localparam int DATA_W = LLR_W * PACK;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FILL  = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    // Symmetric clamp bounds: +(2^(LLR_W-1)-1) and its negation (-32 is never stored).
    localparam logic [LLR_W-1:0] SAT_POS = {1'b0, {(LLR_W-1){1'b1}}};
    localparam logic [LLR_W-1:0] SAT_NEG = {1'b1, {(LLR_W-2){1'b0}}, 1'b1};
    localparam logic [LLR_IN_W-1:0] POS_LIM = {{(LLR_IN_W-LLR_W){1'b0}}, SAT_POS};
    localparam logic [LLR_IN_W-1:0] NEG_LIM = {{(LLR_IN_W-LLR_W){1'b1}}, SAT_NEG};

    logic [1:0]          state_q, state_d;
    logic [LANE_W-1:0]   lane_idx_q, lane_idx_d;
    logic [ADDR_W-1:0]   word_cnt_q, word_cnt_d;
    logic [9:0]          sat_cnt_q, sat_cnt_d;
    logic                ready_q, ready_d;
    logic [DATA_W-1:0]   shadow_q, shadow_d;
    logic                wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]   wr_data_q, wr_data_d;
    logic                end_q, end_d;

    logic                accept;
    logic                last_lane;
    logic                last_word;
    logic                clip_hi;
    logic                clip_lo;
    logic [LLR_W-1:0]    llr_sat;

    assign accept    = llr_valid && ready_q && (state_q == ST_FILL);
    assign last_lane = (lane_idx_q == LANE_W'(PACK-1));
    assign last_word = (word_cnt_q == ADDR_W'(WORD_NUM-1));

    assign clip_hi = ($signed(llr_in) > $signed(POS_LIM));
    assign clip_lo = ($signed(llr_in) < $signed(NEG_LIM));

    always_comb begin
        llr_sat = llr_in[LLR_W-1:0];
        if (clip_hi) begin
            llr_sat = SAT_POS;
        end else if (clip_lo) begin
            llr_sat = SAT_NEG;
        end
    end

    // Each lane latches the saturated sample when it is the lane being filled.
    genvar gi;
    generate
        for (gi = 0; gi < PACK; gi++) begin : g_lane
            assign shadow_d[gi*LLR_W +: LLR_W] =
                (accept && (lane_idx_q == LANE_W'(gi))) ? llr_sat
                                                        : shadow_q[gi*LLR_W +: LLR_W];
        end
    endgenerate

    always_comb begin
        state_d    = state_q;
        lane_idx_d = lane_idx_q;
        word_cnt_d = word_cnt_q;
        sat_cnt_d  = sat_cnt_q;
        ready_d    = ready_q;

        case (state_q)
            ST_IDLE: begin
                ready_d = 1'b0;
                if (flag_org_write_start) begin
                    state_d    = ST_FILL;
                    ready_d    = 1'b1;
                    lane_idx_d = '0;
                    word_cnt_d = '0;
                    sat_cnt_d  = '0;
                end
            end
            ST_FILL: begin
                ready_d = 1'b1;
                if (accept) begin
                    if ((clip_hi || clip_lo) && (sat_cnt_q != 10'h3FF)) begin
                        sat_cnt_d = sat_cnt_q + 10'd1;
                    end
                    if (last_lane) begin
                        lane_idx_d = '0;
                        word_cnt_d = word_cnt_q + ADDR_W'(1);
                        if (last_word) begin
                            ready_d = 1'b0;
                            state_d = ST_FLUSH;
                        end
                    end else begin
                        lane_idx_d = lane_idx_q + LANE_W'(1);
                    end
                end
            end
            ST_FLUSH: begin
                ready_d = 1'b0;
                // Stay here through the end-flag cycle so a coincident start is dropped.
                if (end_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                ready_d = 1'b0;
            end
        endcase
    end

    // Write port outputs are forced to zero outside a write pulse.
    always_comb begin
        wr_en_d   = accept && last_lane;
        wr_addr_d = wr_en_d ? word_cnt_q : '0;
        wr_data_d = wr_en_d ? shadow_d : '0;
        end_d     = (state_q == ST_FLUSH) && wr_en_q;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= ST_IDLE;
            lane_idx_q <= '0;
            word_cnt_q <= '0;
            sat_cnt_q  <= '0;
            ready_q    <= 1'b0;
            shadow_q   <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            end_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            lane_idx_q <= lane_idx_d;
            word_cnt_q <= word_cnt_d;
            sat_cnt_q  <= sat_cnt_d;
            ready_q    <= ready_d;
            shadow_q   <= shadow_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            end_q      <= end_d;
        end
    end

    assign llr_ready          = ready_q;
    assign org_wr_en          = wr_en_q;
    assign org_wr_addr        = wr_addr_q;
    assign org_wr_data        = wr_data_q;
    assign flag_org_write_end = end_q;
    assign sat_cnt            = sat_cnt_q;

endmodule

// File: tb/tb_org_write.sv
// Randomised scoreboard bench for org_write: a stimulus process predicts writes and
// end flags from the clamp/pack rules; a monitor pops and compares them.
module tb_org_write;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  llr_in;
    logic        valid;
    logic        ready;
    logic [6:0]  wr_addr;
    logic [47:0] wr_data;
    logic        wr_en;
    logic        fend;
    logic [9:0]  sat;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    typedef struct { int addr; logic [47:0] data; int cyc; } wr_t;
    typedef struct { int cyc; int sat; } end_t;
    wr_t  wr_q[$];
    end_t end_q[$];

    int sat_tab[8] = '{100, -100, -32, 31, -31, 127, -128, 0};

    org_write dut (
        .sys_clk              (clk),
        .sys_rst_n            (rst_n),
        .flag_org_write_start (start),
        .llr_in               (llr_in),
        .llr_valid            (valid),
        .llr_ready            (ready),
        .org_wr_addr          (wr_addr),
        .org_wr_data          (wr_data),
        .org_wr_en            (wr_en),
        .flag_org_write_end   (fend),
        .sat_cnt              (sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input bit ok, input string name, input string det);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s: %s", name, det);
        end
    endtask

    function automatic int clampv(input int x);
        if (x > 31) return 31;
        if (x < -31) return -31;
        return x;
    endfunction

    // Monitor: compares every DUT write / end pulse against the predicted queues.
    always @(negedge clk) begin
        if (rst_n) begin
            if (wr_en) begin
                if (wr_q.size() == 0) begin
                    chk(1'b0, "unexpected_write", $sformatf("got addr=%0d data=%h, none expected", wr_addr, wr_data));
                end else begin
                    wr_t e;
                    e = wr_q.pop_front();
                    chk((int'(wr_addr) == e.addr) && (wr_data == e.data) && (cyc == e.cyc), "write",
                        $sformatf("got addr=%0d data=%h cyc=%0d, want addr=%0d data=%h cyc=%0d",
                                  wr_addr, wr_data, cyc, e.addr, e.data, e.cyc));
                    $display("[TB] write addr=%0d data=%h cyc=%0d", wr_addr, wr_data, cyc);
                end
            end else begin
                chk((wr_addr == 7'd0) && (wr_data == 48'd0), "idle_zero",
                    $sformatf("got addr=%0d data=%h with en=0, want 0/0", wr_addr, wr_data));
            end
            if (fend) begin
                if (end_q.size() == 0) begin
                    chk(1'b0, "unexpected_end", $sformatf("got end flag at cyc=%0d, none expected", cyc));
                end else begin
                    end_t e;
                    e = end_q.pop_front();
                    chk((cyc == e.cyc) && (int'(sat) == e.sat), "frame_end",
                        $sformatf("got cyc=%0d sat_cnt=%0d, want cyc=%0d sat_cnt=%0d", cyc, sat, e.cyc, e.sat));
                    $display("[TB] frame end cyc=%0d sat_cnt=%0d", cyc, sat);
                end
            end
        end
    end

    // pmode: 0 k%8, 1 clamp pattern then in-range random, 2 full-range random.
    // vmode: 0 continuous, 1 every other cycle, 2 random gaps.
    task automatic run_frame(input int pmode, input int vmode, input int stop_after,
                             input bit mid_start, input bit end_start);
        int acc = 0;
        int addr = 0;
        int idx = 0;
        int nsat = 0;
        int guard = 0;
        int lanes[8];
        int x;
        bit v;
        logic [47:0] w;

        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk(sat == 10'd0, "sat_cleared", $sformatf("got %0d, want 0", sat));

        while (acc < stop_after) begin
            chk(ready == 1'b1, "ready_fill", $sformatf("got %0d at acc=%0d, want 1", ready, acc));
            case (vmode)
                0: v = 1'b1;
                1: v = (guard % 2) == 0;
                default: v = ($urandom_range(0, 3) != 0);
            endcase
            case (pmode)
                0: x = acc % 8;
                1: x = (acc < 8) ? sat_tab[acc] : int'($urandom_range(0, 62)) - 31;
                default: x = int'($urandom_range(0, 255)) - 128;
            endcase
            start  = mid_start && (acc == 163);
            valid  = v;
            llr_in = x[7:0];
            if (v) begin
                lanes[idx] = clampv(x);
                if (x > 31 || x < -31) nsat++;
                idx++;
                acc++;
                if (idx == 8) begin
                    w = '0;
                    for (int i = 0; i < 8; i++) w |= 48'(lanes[i] & 63) << (6 * i);
                    wr_q.push_back('{addr, w, cyc + 1});
                    if (acc == 512) end_q.push_back('{cyc + 2, nsat});
                    addr++;
                    idx = 0;
                end
            end
            guard++;
            if (guard > 4000) begin
                chk(1'b0, "fill_timeout", $sformatf("only %0d samples accepted, want %0d", acc, stop_after));
                break;
            end
            @(negedge clk);
        end
        valid = 1'b0;
        start = 1'b0;

        if (acc == 512) begin
            chk(ready == 1'b0, "ready_drop", $sformatf("got %0d after last sample, want 0", ready));
            @(negedge clk);
            start = end_start;
            @(negedge clk);
            start = 1'b0;
            for (int i = 0; i < 3; i++) begin
                chk(ready == 1'b0, "ready_after_end", $sformatf("got %0d, want 0", ready));
                @(negedge clk);
            end
            for (int i = 0; i < 40 && (wr_q.size() != 0 || end_q.size() != 0); i++) @(negedge clk);
            chk(wr_q.size() == 0 && end_q.size() == 0, "drain",
                $sformatf("got %0d writes / %0d ends outstanding, want 0/0", wr_q.size(), end_q.size()));
            chk(int'(sat) == nsat, "sat_hold", $sformatf("got %0d, want %0d", sat, nsat));
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish, want finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        valid  = 1'b0;
        llr_in = 8'd0;
        #3;
        chk({ready, wr_en, fend} == 3'b000 && wr_addr == 7'd0 && wr_data == 48'd0 && sat == 10'd0,
            "reset_state", $sformatf("got ready=%0d en=%0d end=%0d addr=%0d data=%h sat=%0d, want all 0",
                                     ready, wr_en, fend, wr_addr, wr_data, sat));
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        run_frame(0, 0, 512, 1'b0, 1'b0);
        run_frame(1, 0, 512, 1'b1, 1'b1);
        run_frame(0, 1, 512, 1'b0, 1'b0);
        run_frame(2, 2, 512, 1'b0, 1'b0);

        // Abort mid-frame: 11 words plus 3 lanes, then asynchronous reset mid-cycle.
        run_frame(2, 0, 91, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk(ready == 1'b0, "async_rst_ready", $sformatf("got %0d, want 0", ready));
        chk(wr_en == 1'b0 && fend == 1'b0, "async_rst_strobes", $sformatf("got en=%0d end=%0d, want 0/0", wr_en, fend));
        chk(wr_addr == 7'd0 && wr_data == 48'd0, "async_rst_port", $sformatf("got addr=%0d data=%h, want 0/0", wr_addr, wr_data));
        chk(sat == 10'd0, "async_rst_sat", $sformatf("got %0d, want 0", sat));
        chk(wr_q.size() == 0, "no_pending", $sformatf("got %0d predicted writes outstanding, want 0", wr_q.size()));
        wr_q.delete();
        end_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_frame(2, 2, 512, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
